// File: rtl/sparce_pkg.sv
// Shared definitions for the SparCE skip unit.
// Holds the SASA entry type, table/timeout sizing, the sasa_data field
// positions, the skip FSM state type and the opcode classes that never
// produce a register result.
package sparce_pkg;

  localparam int unsigned SASA_ENTRIES = 4;
  localparam int unsigned SASA_IDX_W   = $clog2(SASA_ENTRIES);
  localparam int unsigned SKIP_TIMEOUT = 16;
  localparam int unsigned TIMEOUT_W    = $clog2(SKIP_TIMEOUT);

  // sasa_data field positions
  localparam int unsigned SD_RS1_LSB   = 0;
  localparam int unsigned SD_RS2_LSB   = 5;
  localparam int unsigned SD_N_LSB     = 10;
  localparam int unsigned SD_VALID_BIT = 16;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;   // 0 = unused operand
    logic [5:0]  n;     // instructions to skip
  } sasa_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT
  } skip_state_t;

  function automatic sasa_entry_t sasa_unpack(input logic [31:0] addr,
                                              input logic [16:0] fields);
    sasa_entry_t e;
    e.valid = fields[SD_VALID_BIT];
    e.pc    = addr;
    e.rs1   = fields[SD_RS1_LSB +: 5];
    e.rs2   = fields[SD_RS2_LSB +: 5];
    e.n     = fields[SD_N_LSB +: 6];
    return e;
  endfunction

  // True when the opcode class writes a destination register.
  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode != OP_STORE) && (opcode != OP_BRANCH) && (opcode != OP_SYSTEM);
  endfunction

endpackage

// File: rtl/sparce_pipeline_if.sv
// Pipeline-side signal group of the SparCE skip unit.
//   pc, rdata, if_ex_enable         : fetch stage 2 instruction and advance
//   wb_en, rd, wb_data              : register writeback
//   sasa_wen, sasa_addr, sasa_data  : SASA table write port
//   skipping, sparce_target         : redirect request (driven by the unit)
// Modport sparce is the unit's view; modport core is the pipeline's view.
interface sparce_pipeline_if;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        if_ex_enable;
  logic        wb_en;
  logic [4:0]  rd;
  logic [31:0] wb_data;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        skipping;
  logic [31:0] sparce_target;

  modport sparce (
    input  pc, rdata, if_ex_enable, wb_en, rd, wb_data,
           sasa_wen, sasa_addr, sasa_data,
    output skipping, sparce_target
  );

  modport core (
    output pc, rdata, if_ex_enable, wb_en, rd, wb_data,
           sasa_wen, sasa_addr, sasa_data,
    input  skipping, sparce_target
  );
endinterface

// File: rtl/sparce_sprf.sv
// Sparsity register file: one "holds zero" bit per architectural register.
//   clk, rst          : clock, async active-high reset (all registers zero)
//   wb_en, rd, wb_data: register writeback
//   rs1, rs2          : lookup addresses
//   rs1_zero, rs2_zero: zero flags, including the same-cycle writeback
module sparce_sprf
  import sparce_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [4:0]  rd,
  input  logic [31:0] wb_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_zero,
  output logic        rs2_zero
);

  logic [31:1] zero_q;
  logic [31:0] zero_view;

  // The bypassed view doubles as the next-state value, so the write and
  // the same-cycle forwarding share one mux; x0 is hardwired to 1.
  always_comb begin
    zero_view = {zero_q, 1'b1};
    if (wb_en && (rd != '0)) begin
      zero_view[rd] = (wb_data == '0);
    end
  end

  assign rs1_zero = zero_view[rs1];
  assign rs2_zero = zero_view[rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= '1;
    end else begin
      zero_q <= zero_view[31:1];
    end
  end

endmodule

// File: rtl/sparce_skip_unit.sv
// SparCE skip unit: when the fetch-stage PC hits a SASA entry whose source
// operands are known zero and not pending in flight, issue a one-cycle
// redirect past the N dependent instructions.
//   clk  : clock
//   rst  : async active-high reset
//   pipe : sparce_pipeline_if.sparce (drives skipping, sparce_target only)
module sparce_skip_unit
  import sparce_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  sparce_pipeline_if.sparce      pipe
);

  sasa_entry_t               table_q [SASA_ENTRIES];
  logic [SASA_IDX_W-1:0]     rr_ptr_q;

  logic [1:0]                sb_valid_q;
  logic [1:0][4:0]           sb_rd_q;

  skip_state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0]      timer_q, timer_d;
  logic [31:0]               target_q, target_d;
  logic                      skip_q, skip_d;
  logic [31:0]               out_tgt_q, out_tgt_d;

  logic                      lu_hit;
  logic [4:0]                lu_rs1, lu_rs2;
  logic [5:0]                lu_n;
  logic                      wr_hit;
  logic [SASA_IDX_W-1:0]     wr_idx;
  logic                      rs1_zero, rs2_zero;
  logic                      hazard;
  logic                      trigger;
  logic [31:0]               skip_target;
  logic                      sb_new_valid;
  logic [1:0]                sb_clr;
  logic                      unused_bits;

  assign unused_bits = ^{pipe.sasa_data[31:17], pipe.rdata[31:12]};

  // Lookup reads the registered table, so a same-cycle write is not seen.
  always_comb begin
    lu_hit = 1'b0;
    lu_rs1 = '0;
    lu_rs2 = '0;
    lu_n   = '0;
    for (int unsigned i = 0; i < SASA_ENTRIES; i++) begin
      if (table_q[i].valid && (table_q[i].pc == pipe.pc)) begin
        lu_hit = 1'b1;
        lu_rs1 = table_q[i].rs1;
        lu_rs2 = table_q[i].rs2;
        lu_n   = table_q[i].n;
      end
    end
  end

  always_comb begin
    wr_hit = 1'b0;
    wr_idx = rr_ptr_q;
    for (int unsigned i = 0; i < SASA_ENTRIES; i++) begin
      if (table_q[i].valid && (table_q[i].pc == pipe.sasa_addr)) begin
        wr_hit = 1'b1;
        wr_idx = SASA_IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SASA_ENTRIES; i++) begin
        table_q[i] <= '0;
      end
      rr_ptr_q <= '0;
    end else if (pipe.sasa_wen) begin
      table_q[wr_idx] <= sasa_unpack(pipe.sasa_addr, pipe.sasa_data[16:0]);
      if (!wr_hit) begin
        rr_ptr_q <= rr_ptr_q + 1'b1;
      end
    end
  end

  sparce_sprf u_sprf (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (pipe.wb_en),
    .rd       (pipe.rd),
    .wb_data  (pipe.wb_data),
    .rs1      (lu_rs1),
    .rs2      (lu_rs2),
    .rs1_zero (rs1_zero),
    .rs2_zero (rs2_zero)
  );

  // In-flight scoreboard: slot 0 is the newest accepted instruction.
  always_comb begin
    sb_new_valid = writes_rd(pipe.rdata[6:0]) && (pipe.rdata[11:7] != '0);
    for (int unsigned j = 0; j < 2; j++) begin
      sb_clr[j] = pipe.wb_en && (sb_rd_q[j] == pipe.rd);
    end
  end

  // A writeback clears the slot even as it shifts; the incoming instruction
  // is younger than any writeback, so it is never cleared on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_q <= '0;
      sb_rd_q    <= '0;
    end else if (pipe.if_ex_enable) begin
      sb_valid_q[1] <= sb_valid_q[0] && !sb_clr[0];
      sb_rd_q[1]    <= sb_rd_q[0];
      sb_valid_q[0] <= sb_new_valid;
      sb_rd_q[0]    <= pipe.rdata[11:7];
    end else begin
      sb_valid_q <= sb_valid_q & ~sb_clr;
    end
  end

  // Valid slots never hold rd=0, so an unused rs2 (0) cannot match.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned j = 0; j < 2; j++) begin
      if (sb_valid_q[j] && ((sb_rd_q[j] == lu_rs1) || (sb_rd_q[j] == lu_rs2))) begin
        hazard = 1'b1;
      end
    end
  end

  assign trigger = (state_q == ST_IDLE) && pipe.if_ex_enable && lu_hit &&
                   rs1_zero && ((lu_rs2 == '0) || rs2_zero) && !hazard;

  assign skip_target = pipe.pc + (({26'd0, lu_n} + 32'd1) << 2);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    target_d  = target_q;
    skip_d    = 1'b0;
    out_tgt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d   = ST_SKIP;
          skip_d    = 1'b1;
          out_tgt_d = skip_target;
          target_d  = skip_target;
        end
      end
      ST_SKIP: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        if ((pipe.if_ex_enable && (pipe.pc == target_q)) ||
            (timer_q == TIMEOUT_W'(SKIP_TIMEOUT - 1))) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      target_q  <= '0;
      skip_q    <= 1'b0;
      out_tgt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      target_q  <= target_d;
      skip_q    <= skip_d;
      out_tgt_q <= out_tgt_d;
    end
  end

  assign pipe.skipping      = skip_q;
  assign pipe.sparce_target = out_tgt_q;

endmodule
